// File: rtl/mac_cfg_seq.sv
// mac_cfg_seq
// Avalon-MM master that programs a MAC/PHY management register block after
// power-up. It waits a fixed delay, then writes a constant table of
// address/data pairs and, optionally, reads each entry back to confirm it.
// Mismatches are retried a bounded number of times; stalled transfers time
// out. Completion or failure is reported through sticky done/error flags.
// A start pulse in DONE or ERR replays the table without the power-up delay.
module mac_cfg_seq #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int NUM_ENTRIES = 3,
    parameter logic [NUM_ENTRIES*ADDR_W-1:0] INIT_ADDR = {8'h94, 8'h0e, 8'h02},
    parameter logic [NUM_ENTRIES*DATA_W-1:0] INIT_DATA = {32'h7, 32'h4, 32'h01000093},
    parameter int WAIT_CYCLES = 8,
    parameter bit VERIFY      = 1'b1,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              read,
    output logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        err_index
);

    // The table is padded to 16 entries so the 4-bit entry index always
    // addresses it exactly; padding entries are never visited.
    localparam int TAB_DEPTH = 16;

    localparam logic [7:0] DELAY_LAST = 8'(WAIT_CYCLES);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] RETRY_MAX  = 8'(MAX_RETRY);
    localparam logic [3:0] LAST_IDX   = 4'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_DELAY,
        S_LOAD,
        S_WR,
        S_RD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_reg;
    logic [7:0]        delay_cnt_reg;
    logic [7:0]        tmo_cnt_reg;
    logic [7:0]        retry_reg;
    logic [3:0]        idx_reg;
    logic [3:0]        idx_next;
    logic [DATA_W-1:0] rdata_reg;

    logic [ADDR_W-1:0] addr_tab [TAB_DEPTH];
    logic [DATA_W-1:0] data_tab [TAB_DEPTH];

    // Unpack the flattened parameter vectors into indexable tables.
    genvar gi;
    generate
        for (gi = 0; gi < TAB_DEPTH; gi++) begin : g_tab
            if (gi < NUM_ENTRIES) begin : g_used
                assign addr_tab[gi] = INIT_ADDR[gi*ADDR_W +: ADDR_W];
                assign data_tab[gi] = INIT_DATA[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign addr_tab[gi] = '0;
                assign data_tab[gi] = '0;
            end
        end
    endgenerate

    assign idx_next = idx_reg + 4'd1;

    // Sequencer: delay, then load/write/read/check each entry in turn.
    // Every output is registered; a strobe is raised one state after the
    // previous transfer ended, which guarantees an idle cycle between them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_DELAY;
            delay_cnt_reg <= '0;
            tmo_cnt_reg   <= '0;
            retry_reg     <= '0;
            idx_reg       <= '0;
            rdata_reg     <= '0;
            address       <= '0;
            writedata     <= '0;
            write         <= 1'b0;
            read          <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            err_index     <= '0;
        end else begin
            case (state_reg)
                S_DELAY: begin
                    if (delay_cnt_reg == DELAY_LAST) begin
                        delay_cnt_reg <= '0;
                        idx_reg       <= '0;
                        retry_reg     <= '0;
                        state_reg     <= S_LOAD;
                    end else begin
                        delay_cnt_reg <= delay_cnt_reg + 8'd1;
                    end
                end

                S_LOAD: begin
                    address     <= addr_tab[idx_reg];
                    writedata   <= data_tab[idx_reg];
                    write       <= 1'b1;
                    tmo_cnt_reg <= '0;
                    state_reg   <= S_WR;
                end

                S_WR: begin
                    if (!waitrequest) begin
                        write <= 1'b0;
                        if (VERIFY) begin
                            state_reg <= S_RD;
                        end else if (idx_reg == LAST_IDX) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            retry_reg <= '0;
                            state_reg <= S_LOAD;
                        end
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        // Stalled too long: abandon without retrying.
                        write     <= 1'b0;
                        error     <= 1'b1;
                        err_index <= idx_reg;
                        busy      <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end

                S_RD: begin
                    if (!read) begin
                        // First cycle in RD is the idle gap after the write.
                        read        <= 1'b1;
                        tmo_cnt_reg <= '0;
                    end else if (!waitrequest) begin
                        rdata_reg <= readdata;
                        read      <= 1'b0;
                        state_reg <= S_CHK;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        read      <= 1'b0;
                        error     <= 1'b1;
                        err_index <= idx_reg;
                        busy      <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end

                S_CHK: begin
                    if (rdata_reg == data_tab[idx_reg]) begin
                        if (idx_reg == LAST_IDX) begin
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_DONE;
                        end else begin
                            idx_reg   <= idx_next;
                            retry_reg <= '0;
                            state_reg <= S_LOAD;
                        end
                    end else if (retry_reg == RETRY_MAX) begin
                        error     <= 1'b1;
                        err_index <= idx_reg;
                        busy      <= 1'b0;
                        state_reg <= S_ERR;
                    end else begin
                        retry_reg <= retry_reg + 8'd1;
                        state_reg <= S_LOAD;
                    end
                end

                S_DONE, S_ERR: begin
                    // Re-run from entry 0, skipping the power-up delay.
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        err_index <= '0;
                        busy      <= 1'b1;
                        idx_reg   <= '0;
                        retry_reg <= '0;
                        state_reg <= S_LOAD;
                    end
                end

                default: begin
                    state_reg <= S_DELAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_cfg_seq.sv
// Directed testbench for mac_cfg_seq: a responder with programmable stall,
// stuck-waitrequest and corrupted read-back, a transfer monitor, and a
// linear sequence of directed steps checked by immediate assertions.
module tb_mac_cfg_seq;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default table, VERIFY=1, TIMEOUT=20
    logic        reset, start, waitrequest;
    logic [31:0] readdata, writedata;
    logic [7:0]  address;
    logic        write, read, busy, done, error;
    logic [3:0]  err_index;

    // Instance B: single entry, no verify
    logic        reset1, start1, waitrequest1;
    logic [31:0] readdata1, writedata1;
    logic [7:0]  address1;
    logic        write1, read1, busy1, done1, error1;
    logic [3:0]  err_index1;

    mac_cfg_seq #(.TIMEOUT(20)) u_dut (
        .clk(clk), .reset(reset), .start(start), .waitrequest(waitrequest),
        .readdata(readdata), .address(address), .write(write), .read(read),
        .writedata(writedata), .busy(busy), .done(done), .error(error),
        .err_index(err_index)
    );

    mac_cfg_seq #(
        .NUM_ENTRIES(1), .INIT_ADDR(8'h02), .INIT_DATA(32'h01000093), .VERIFY(1'b0)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .start(start1), .waitrequest(waitrequest1),
        .readdata(readdata1), .address(address1), .write(write1), .read(read1),
        .writedata(writedata1), .busy(busy1), .done(done1), .error(error1),
        .err_index(err_index1)
    );

    int checks = 0;
    int errors = 0;

    // Responder controls
    int   stall_n  = 0;
    bit   bad_en   = 1'b0;
    bit   stuck_en = 1'b0;
    int   stall_cnt = 0;
    logic [31:0] mem [256];

    // Monitor results
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  rd_addr_q[$];
    logic [31:0] rd_data_q[$];
    int len_q[$];
    int run_len = 0;
    int last_abort_len = 0;
    int unstable_cnt = 0;
    int overlap_cnt = 0;
    int b2b_cnt = 0;
    int both_cnt = 0;
    bit prev_done = 1'b0;
    logic [7:0]  snap_addr;
    logic [31:0] snap_data;
    logic        snap_wr;
    int b_wr_cnt = 0;
    int b_rd_cnt = 0;
    int b_wr_hi = 0;

    logic [7:0]  exp_addr [3];
    logic [31:0] exp_data [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        rd_data_q.delete();
        len_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until write is seen; optionally pulse start at step start_at.
    task automatic measure_first_write(input string tag, input int exp_k, input int start_at);
        int k;
        k = 0;
        for (int i = 1; i <= 60 && k == 0; i++) begin
            @(negedge clk);
            if (write) k = i;
            start = (i == start_at);
        end
        start = 1'b0;
        check(tag, 32'(k), 32'(exp_k));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Responder for instance A: decides waitrequest and readdata on negedges.
    initial begin
        waitrequest = 1'b0;
        readdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (write || read) begin
                if (stuck_en && write && address == 8'h94) begin
                    waitrequest = 1'b1;
                end else if (stall_cnt < stall_n) begin
                    waitrequest = 1'b1;
                    stall_cnt++;
                end else begin
                    waitrequest = 1'b0;
                end
            end else begin
                waitrequest = 1'b0;
                stall_cnt = 0;
            end
            readdata = (bad_en && address == 8'h0e) ? 32'h5 : mem[address];
        end
    end

    // Monitor for instance A: logs transfers and protocol-rule violations.
    initial begin
        forever begin
            @(posedge clk);
            if (write && read) overlap_cnt++;
            if (done && error) both_cnt++;
            if (write || read) begin
                if (prev_done) b2b_cnt++;
                if (run_len == 0) begin
                    snap_addr = address;
                    snap_data = writedata;
                    snap_wr   = write;
                end else if (address != snap_addr || writedata != snap_data || write != snap_wr) begin
                    unstable_cnt++;
                end
                run_len++;
                if (!waitrequest) begin
                    if (write) begin
                        wr_addr_q.push_back(address);
                        wr_data_q.push_back(writedata);
                        mem[address] = writedata;
                        $display("%0t A WR addr=%02h data=%08h cycles=%0d", $time, address, writedata, run_len);
                    end else begin
                        rd_addr_q.push_back(address);
                        rd_data_q.push_back(readdata);
                        $display("%0t A RD addr=%02h data=%08h cycles=%0d", $time, address, readdata, run_len);
                    end
                    len_q.push_back(run_len);
                    run_len = 0;
                    prev_done = 1'b1;
                end else begin
                    prev_done = 1'b0;
                end
            end else begin
                if (run_len != 0) begin
                    last_abort_len = run_len;
                    $display("%0t A ABORT addr=%02h cycles=%0d", $time, snap_addr, run_len);
                end
                run_len = 0;
                prev_done = 1'b0;
            end
        end
    end

    // Monitor for instance B.
    initial begin
        forever begin
            @(posedge clk);
            if (write1) b_wr_hi++;
            if (write1 && !waitrequest1) begin
                b_wr_cnt++;
                $display("%0t B WR addr=%02h data=%08h", $time, address1, writedata1);
            end
            if (read1) b_rd_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_addr[0] = 8'h02; exp_data[0] = 32'h01000093;
        exp_addr[1] = 8'h0e; exp_data[1] = 32'h4;
        exp_addr[2] = 8'h94; exp_data[2] = 32'h7;
        waitrequest1 = 1'b0;
        readdata1 = '0;
        reset = 1'b1; start = 1'b0;
        reset1 = 1'b1; start1 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_address",   32'(address),   32'd0);
        check("rst_writedata", writedata,      32'd0);
        check("rst_write",     32'(write),     32'd0);
        check("rst_read",      32'(read),      32'd0);
        check("rst_busy",      32'(busy),      32'd1);
        check("rst_done",      32'(done),      32'd0);
        check("rst_error",     32'(error),     32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);

        // Test 1: defaults, no stalls, read-back mirrors memory
        reset = 1'b0;
        measure_first_write("t1_first_wr_cycle", W + 2, 0);
        check("t1_first_addr", 32'(address), 32'h02);
        check("t1_first_data", writedata, 32'h01000093);
        wait_idle("t1_idle", 400);
        check("t1_done",  32'(done),  32'd1);
        check("t1_error", 32'(error), 32'd0);
        check("t1_wr_count", 32'(wr_addr_q.size()), 32'd3);
        check("t1_rd_count", 32'(rd_addr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_wr_addr%0d", i), 32'(wr_addr_q[i]), 32'(exp_addr[i]));
            check($sformatf("t1_wr_data%0d", i), wr_data_q[i], exp_data[i]);
            check($sformatf("t1_rd_addr%0d", i), 32'(rd_addr_q[i]), 32'(exp_addr[i]));
        end

        // Test 2: every transfer stalled 5 cycles
        clear_q();
        stall_n = 5;
        pulse_start();
        check("t2_busy_after_start", 32'(busy), 32'd1);
        check("t2_done_cleared", 32'(done), 32'd0);
        wait_idle("t2_idle", 600);
        check("t2_done", 32'(done), 32'd1);
        check("t2_xfer_count", 32'(len_q.size()), 32'd6);
        for (int i = 0; i < len_q.size(); i++)
            check($sformatf("t2_len%0d", i), 32'(len_q[i]), 32'd6);
        check("t2_unstable", 32'(unstable_cnt), 32'd0);

        // Test 3: entry 1 reads back 0x5 every time
        clear_q();
        stall_n = 0;
        bad_en = 1'b1;
        pulse_start();
        wait_idle("t3_idle", 600);
        check("t3_error", 32'(error), 32'd1);
        check("t3_err_index", 32'(err_index), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_wr_count", 32'(wr_addr_q.size()), 32'd4);
        check("t3_rd_count", 32'(rd_addr_q.size()), 32'd4);
        for (int i = 1; i < 4; i++)
            check($sformatf("t3_wr_addr%0d", i), 32'(wr_addr_q[i]), 32'h0e);
        begin
            int n94;
            n94 = 0;
            foreach (wr_addr_q[i]) if (wr_addr_q[i] == 8'h94) n94++;
            foreach (rd_addr_q[i]) if (rd_addr_q[i] == 8'h94) n94++;
            check("t3_no_94", 32'(n94), 32'd0);
        end

        // Test 4: waitrequest stuck on entry 2 write, TIMEOUT=20
        clear_q();
        bad_en = 1'b0;
        stuck_en = 1'b1;
        last_abort_len = 0;
        pulse_start();
        check("t4_error_cleared", 32'(error), 32'd0);
        wait_idle("t4_idle", 600);
        check("t4_error", 32'(error), 32'd1);
        check("t4_err_index", 32'(err_index), 32'd2);
        check("t4_done", 32'(done), 32'd0);
        check("t4_abort_len", 32'(last_abort_len), 32'd20);
        check("t4_write_low", 32'(write), 32'd0);
        check("t4_wr_count", 32'(wr_addr_q.size()), 32'd2);

        // Test 6: reset in the middle of entry 1 write, start while busy
        stuck_en = 1'b0;
        stall_n = 5;
        pulse_start();
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                @(negedge clk);
                if (write && address == 8'h0e) found = 1'b1;
            end
            check("t6_reach_entry1", 32'(found), 32'd1);
        end
        @(negedge clk);
        check("t6_write_held", 32'(write), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("t6_write_dropped", 32'(write), 32'd0);
        check("t6_busy_in_reset", 32'(busy), 32'd1);
        check("t6_addr_in_reset", 32'(address), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_q();
        measure_first_write("t6_first_wr_cycle", W + 2, 3);
        check("t6_first_addr", 32'(address), 32'h02);
        pulse_start();
        wait_idle("t6_idle", 600);
        check("t6_done", 32'(done), 32'd1);
        check("t6_wr_count", 32'(wr_addr_q.size()), 32'd3);
        check("t6_rd_count", 32'(rd_addr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t6_wr_addr%0d", i), 32'(wr_addr_q[i]), 32'(exp_addr[i]));

        // Test 5: instance B, VERIFY=0, NUM_ENTRIES=1
        reset1 = 1'b0;
        begin
            int k;
            k = 0;
            for (int i = 1; i <= 60 && k == 0; i++) begin
                @(negedge clk);
                if (write1) k = i;
            end
            check("t5_first_wr_cycle", 32'(k), 32'(W + 2));
            check("t5_addr", 32'(address1), 32'h02);
            for (int i = 0; i < 50 && busy1; i++) @(negedge clk);
            @(negedge clk);
            check("t5_done", 32'(done1), 32'd1);
            check("t5_busy", 32'(busy1), 32'd0);
            check("t5_wr_count", 32'(b_wr_cnt), 32'd1);
            check("t5_wr_cycles", 32'(b_wr_hi), 32'd1);
            check("t5_rd_count", 32'(b_rd_cnt), 32'd0);

            start1 = 1'b1;
            k = 0;
            for (int i = 1; i <= 20 && k == 0; i++) begin
                @(negedge clk);
                start1 = 1'b0;
                if (write1) k = i;
            end
            start1 = 1'b0;
            check("t5_restart_wr_cycle", 32'(k), 32'd2);
            for (int i = 0; i < 50 && busy1; i++) @(negedge clk);
            @(negedge clk);
            check("t5_done2", 32'(done1), 32'd1);
            check("t5_wr_count2", 32'(b_wr_cnt), 32'd2);
            check("t5_wr_cycles2", 32'(b_wr_hi), 32'd2);
            check("t5_rd_count2", 32'(b_rd_cnt), 32'd0);
        end

        // Protocol rules over the whole run
        check("rule_no_overlap", 32'(overlap_cnt), 32'd0);
        check("rule_idle_gap", 32'(b2b_cnt), 32'd0);
        check("rule_done_error_excl", 32'(both_cnt), 32'd0);
        check("rule_stable", 32'(unstable_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
